fir_host_seq: RTL

Host-side job sequencer for the FIR core: the initiator side of the START/pracuje/DONE control handshake and the writer/reader of the FIR memories. It accepts one job from an input stream: n_wsp coefficients followed by n_probek samples. It writes them into the coefficient and sample memories while the core is idle, then pulses START and waits for DONE. Finally it reads n_probek results from the output memory and streams them out with valid/ready.

---
 rtl/fir_host_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fir_host_seq.sv
// rtl/fir_host_seq.sv - host-side job sequencer for the FIR core (load, START/DONE, readout)
// Optional watchdog on DONE: define FIR_HOST_TIMEOUT_EN.
module fir_host_seq #(
   parameter int DATA_W      = 16,
   parameter int OUT_W       = 40,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [ADDR_W-1:0] n_wsp,
   input  logic [ADDR_W-1:0] n_probek,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              wr_en,
   output logic              wr_sel,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              START,
   input  logic              pracuje,
   input  logic              DONE,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [OUT_W-1:0]  rd_data,
   output logic [OUT_W-1:0]  m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              job_done,
   output logic              err_timeout
);

   typedef enum logic [2:0] {
      IDLE, LOAD_WSP, LOAD_PROB, KICK, WAIT_DONE, RD_REQ, RD_CAP, OUT
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] len_wsp, len_prob, idx, idx_n;
   logic              accept, s_hs, m_hs, last_wsp, last_prob, expire;

   always_comb begin
      accept    = go && !pracuje && (n_wsp != '0) && (n_probek != '0);
      s_hs      = s_valid && s_ready;
      m_hs      = m_valid && m_ready;
      last_wsp  = (idx == len_wsp - ADDR_W'(1));
      last_prob = (idx == len_prob - ADDR_W'(1));
      state_n   = state;
      idx_n     = idx;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = LOAD_WSP;
               idx_n   = '0;
            end
         end
         LOAD_WSP: begin
            if (s_hs) begin
               idx_n = last_wsp ? '0 : idx + ADDR_W'(1);
               if (last_wsp) state_n = LOAD_PROB;
            end
         end
         LOAD_PROB: begin
            if (s_hs) begin
               idx_n = idx + ADDR_W'(1);
               if (last_prob) state_n = KICK;
            end
         end
         KICK: state_n = WAIT_DONE;
         WAIT_DONE: begin
            // DONE takes priority over a watchdog expiry in the same cycle
            if (DONE) begin
               state_n = RD_REQ;
               idx_n   = '0;
            end else if (expire) begin
               state_n = IDLE;
            end
         end
         RD_REQ: state_n = RD_CAP;
         RD_CAP: state_n = OUT;
         OUT: begin
            if (m_hs) begin
               if (last_prob) begin
                  state_n = IDLE;
               end else begin
                  state_n = RD_REQ;
                  idx_n   = idx + ADDR_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         len_wsp  <= '0;
         len_prob <= '0;
         s_ready  <= 1'b0;
         wr_en    <= 1'b0;
         wr_sel   <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         START    <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         m_data   <= '0;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         busy     <= 1'b0;
         job_done <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         if (state == IDLE && accept) begin
            len_wsp  <= n_wsp;
            len_prob <= n_probek;
         end
         // outputs are decoded from the next state so they line up with it
         s_ready <= (state_n == LOAD_WSP) || (state_n == LOAD_PROB);
         wr_en   <= s_hs;
         if (s_hs) begin
            wr_sel  <= (state == LOAD_PROB);
            wr_addr <= idx;
            wr_data <= s_data;
         end
         START <= (state == KICK);
         rd_en <= (state_n == RD_REQ);
         if (state_n == RD_REQ) rd_addr <= idx_n;
         if (state == RD_CAP) m_data <= rd_data;
         m_valid  <= (state_n == OUT);
         m_last   <= (state_n == OUT) && (idx_n == len_prob - ADDR_W'(1));
         busy     <= (state_n != IDLE);
         job_done <= (state == OUT) && m_hs && last_prob;
      end
   end

`ifdef FIR_HOST_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd;

   assign expire = (state == WAIT_DONE) && (wd == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd          <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state == KICK) wd <= '0;
         else if (state == WAIT_DONE) wd <= wd + WD_W'(1);
         err_timeout <= expire && !DONE;
      end
   end
`else
   assign expire      = 1'b0;
   // constant 0; the comparison only keeps the parameter referenced
   assign err_timeout = (TIMEOUT_CYC < 0) ? 1'b1 : 1'b0;
`endif

endmodule
